// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
//   Groups the control and status signals of countdown_timer.
//   Clock and reset are kept outside the interface as plain module ports.
//
//   Signals
//     timer_enable      master -> slave   count enable; low pauses counting
//     timer_load        master -> slave   synchronous load strobe
//     timer_load_value  master -> slave   value taken on load (WIDTH bits)
//     timer_mode        master -> slave   0 one-shot, 1 auto-reload
//     timer_number      slave  -> master  current count (registered)
//     timer_overflow    slave  -> master  high while count is 0 after expiry
//     timer_expire      slave  -> master  one-cycle pulse on each expiry
//     timer_warn        slave  -> master  high while running and 0 < count <= WARN
//     timer_state       slave  -> master  debug view of the FSM state
//                                         (0 IDLE, 1 RUN, 2 DONE)
//
//   Handshake: there is no valid/ready pairing. timer_load is a
//   single-cycle strobe that is always accepted on the rising clock edge
//   where it is high; timer_enable is a level that is sampled every cycle.
// -----------------------------------------------------------------------------
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             timer_enable;
    logic             timer_load;
    logic [WIDTH-1:0] timer_load_value;
    logic             timer_mode;
    logic [WIDTH-1:0] timer_number;
    logic             timer_overflow;
    logic             timer_expire;
    logic             timer_warn;
    logic [1:0]       timer_state;

    modport master (
        output timer_enable,
        output timer_load,
        output timer_load_value,
        output timer_mode,
        input  timer_number,
        input  timer_overflow,
        input  timer_expire,
        input  timer_warn,
        input  timer_state
    );

    modport slave (
        input  timer_enable,
        input  timer_load,
        input  timer_load_value,
        input  timer_mode,
        output timer_number,
        output timer_overflow,
        output timer_expire,
        output timer_warn,
        output timer_state
    );
endinterface

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Prescaled down-counter with one-shot and auto-reload modes, a synchronous
//   load, an expiry pulse, an overflow level and an optional warning flag.
//
//   Parameters
//     WIDTH     counter width in bits (2..16)
//     INIT      reload value after reset / in auto-reload (1..2^WIDTH-1)
//     PRESCALE  timer_clk cycles per count step (1..65535)
//     WARN      warning threshold (0..INIT)
//
//   Ports
//     timer_clk    sole clock, rising edge
//     timer_reset  asynchronous, active-low reset
//     tif          countdown_timer_if.slave (enable, load, load value, mode in;
//                  number, overflow, expire, warn, debug state out)
//
//   Build option
//     COUNTDOWN_TIMER_WARN_EN  when defined, timer_warn is driven from a
//                              registered threshold compare; otherwise it is
//                              tied low and no compare is built.
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH    = 4,
    parameter int INIT     = 15,
    parameter int PRESCALE = 1,
    parameter int WARN     = 3
) (
    input  logic               timer_clk,
    input  logic               timer_reset,
    countdown_timer_if.slave   tif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0]      PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] INIT_V     = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE_V      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V     = '0;

    // Reject illegal parameter sets at elaboration time.
    generate
        if (WIDTH < 2 || WIDTH > 16 || INIT < 1 || INIT > (1 << WIDTH) - 1 ||
            PRESCALE < 1 || PRESCALE > 65535 || WARN < 0 || WARN > INIT) begin : g_bad_params
            $error("countdown_timer: parameter out of range");
        end
    endgenerate

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [15:0]      presc_q,  presc_d;
    logic             ovf_q,    ovf_d;
    logic             expire_q, expire_d;

    // -------------------------------------------------------------------------
    // Next-state logic. Load beats everything, including a tick in the same
    // cycle. A tick only exists in RUN with enable high and the prescaler on
    // its last step; with enable low in RUN every register simply holds.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = presc_q;
        ovf_d    = ovf_q;
        expire_d = 1'b0;

        if (tif.timer_load) begin
            count_d = tif.timer_load_value;
            presc_d = '0;
            // A zero load lands directly in the expired condition, but
            // without an expiry pulse.
            ovf_d   = (tif.timer_load_value == ZERO_V);
            if (tif.timer_load_value == ZERO_V && !tif.timer_mode) begin
                state_d = ST_DONE;
            end else if (tif.timer_enable) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tif.timer_enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tif.timer_enable) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            if (count_q > ONE_V) begin
                                count_d = count_q - ONE_V;
                                ovf_d   = 1'b0;
                            end else if (count_q == ONE_V) begin
                                count_d  = ZERO_V;
                                ovf_d    = 1'b1;
                                expire_d = 1'b1;
                                if (!tif.timer_mode) begin
                                    state_d = ST_DONE;
                                end
                            end else if (tif.timer_mode) begin
                                // Sitting at 0 in auto-reload: this tick
                                // starts the next period.
                                count_d = INIT_V;
                                ovf_d   = 1'b0;
                            end else begin
                                // Mode was switched to one-shot while at 0.
                                state_d = ST_DONE;
                            end
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // Terminal until load or reset: count 0, overflow 1.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge timer_clk or negedge timer_reset) begin
        if (!timer_reset) begin
            state_q  <= ST_IDLE;
            count_q  <= INIT_V;
            presc_q  <= '0;
            ovf_q    <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            ovf_q    <= ovf_d;
            expire_q <= expire_d;
        end
    end

`ifdef COUNTDOWN_TIMER_WARN_EN
    localparam logic [WIDTH-1:0] WARN_V = WIDTH'(WARN);

    logic warn_q, warn_d;

    // Computed from the next count/state so the flag lines up with
    // timer_number in the same cycle.
    always_comb begin
        warn_d = (state_d == ST_RUN) && (count_d != ZERO_V) && (count_d <= WARN_V);
    end

    always_ff @(posedge timer_clk or negedge timer_reset) begin
        if (!timer_reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign tif.timer_warn = warn_q;
`else
    assign tif.timer_warn = 1'b0;
`endif

    assign tif.timer_number   = count_q;
    assign tif.timer_overflow = ovf_q;
    assign tif.timer_expire   = expire_q;
    assign tif.timer_state    = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Three timer instances run side by side:
//     u0  defaults (INIT 15, PRESCALE 1)
//     u1  INIT 3,  PRESCALE 4, auto-reload
//     u2  INIT 12, PRESCALE 3, one-shot, paused mid-prescale
//   A per-instance behavioural model advances on every rising edge and is
//   compared against all outputs on every falling edge. Directed sequences
//   add hand-computed literal checks sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam bit WARN_EN =
`ifdef COUNTDOWN_TIMER_WARN_EN
    1'b1;
`else
    1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(4)) if0 ();
  countdown_timer_if #(.WIDTH(4)) if1 ();
  countdown_timer_if #(.WIDTH(4)) if2 ();

  countdown_timer #(.WIDTH(4)) u0 (.timer_clk(clk), .timer_reset(rst_n), .tif(if0));
  countdown_timer #(.WIDTH(4), .INIT(3), .PRESCALE(4), .WARN(3)) u1 (
    .timer_clk(clk), .timer_reset(rst_n), .tif(if1));
  countdown_timer #(.WIDTH(4), .INIT(12), .PRESCALE(3), .WARN(3)) u2 (
    .timer_clk(clk), .timer_reset(rst_n), .tif(if2));

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. ph: 0 waiting for enable, 1 counting, 2 finished.
  // ---------------------------------------------------------------------------
  typedef struct {
    int ph;
    int cnt;
    int pre;
    bit ovf;
    bit exp;
    bit wrn;
  } mdl_t;

  function automatic mdl_t mreset(input int init);
    mdl_t r;
    r.ph = 0; r.cnt = init; r.pre = 0; r.ovf = 0; r.exp = 0; r.wrn = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit en, input bit ld, input int lv,
                                 input bit md, input int init, input int presc, input int warn);
    mdl_t n = m;
    n.exp = 0;
    if (ld) begin
      n.cnt = lv;
      n.pre = 0;
      n.ovf = (lv == 0);
      if (lv == 0 && !md) n.ph = 2;
      else n.ph = en ? 1 : 0;
    end else if (m.ph == 0) begin
      if (en) n.ph = 1;
    end else if (m.ph == 1 && en) begin
      if (m.pre + 1 < presc) begin
        n.pre = m.pre + 1;
      end else begin
        n.pre = 0;
        if (m.cnt >= 2) begin
          n.cnt = m.cnt - 1;
          n.ovf = 0;
        end else if (m.cnt == 1) begin
          n.cnt = 0; n.ovf = 1; n.exp = 1;
          if (!md) n.ph = 2;
        end else if (md) begin
          n.cnt = init; n.ovf = 0;
        end else begin
          n.ph = 2;
        end
      end
    end
    n.wrn = WARN_EN && n.ph == 1 && n.cnt >= 1 && n.cnt <= warn;
    return n;
  endfunction

  mdl_t m0, m1, m2;

  always @(posedge clk) begin
    if (rst_n) begin
      m0 = mstep(m0, if0.timer_enable, if0.timer_load, int'(if0.timer_load_value),
                 if0.timer_mode, 15, 1, 3);
      m1 = mstep(m1, if1.timer_enable, if1.timer_load, int'(if1.timer_load_value),
                 if1.timer_mode, 3, 4, 3);
      m2 = mstep(m2, if2.timer_enable, if2.timer_load, int'(if2.timer_load_value),
                 if2.timer_mode, 12, 3, 3);
    end
  end

  always @(negedge rst_n) begin
    m0 = mreset(15);
    m1 = mreset(3);
    m2 = mreset(12);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare, every falling edge
  // ---------------------------------------------------------------------------
  task automatic cmp_dut(input string nm, input int num, input bit ovf, input bit ex,
                         input bit wr, input int st, input mdl_t m);
    chk({nm, ".number"},   num, m.cnt);
    chk({nm, ".overflow"}, int'(ovf), int'(m.ovf));
    chk({nm, ".expire"},   int'(ex), int'(m.exp));
    chk({nm, ".warn"},     int'(wr), int'(m.wrn));
    chk({nm, ".state"},    st, m.ph);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_dut("u0", int'(if0.timer_number), if0.timer_overflow, if0.timer_expire,
              if0.timer_warn, int'(if0.timer_state), m0);
      cmp_dut("u1", int'(if1.timer_number), if1.timer_overflow, if1.timer_expire,
              if1.timer_warn, int'(if1.timer_state), m1);
      cmp_dut("u2", int'(if2.timer_number), if2.timer_overflow, if2.timer_expire,
              if2.timer_warn, int'(if2.timer_state), m2);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit en, input bit ld, input int lv, input bit md);
    if0.timer_enable     = en;
    if0.timer_load       = ld;
    if0.timer_load_value = 4'(lv);
    if0.timer_mode       = md;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c0, c1, c2, t1;
    m0 = mreset(15);
    m1 = mreset(3);
    m2 = mreset(12);
    drive0(1'b0, 1'b0, 0, 1'b0);
    if1.timer_enable = 1'b0; if1.timer_load = 1'b0; if1.timer_load_value = '0; if1.timer_mode = 1'b1;
    if2.timer_enable = 1'b0; if2.timer_load = 1'b0; if2.timer_load_value = '0; if2.timer_mode = 1'b0;
    #1 cmp_on = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst.u0.number",   int'(if0.timer_number), 15);
    chk("rst.u0.overflow", int'(if0.timer_overflow), 0);
    chk("rst.u0.expire",   int'(if0.timer_expire), 0);
    chk("rst.u0.warn",     int'(if0.timer_warn), 0);
    chk("rst.u1.number",   int'(if1.timer_number), 3);

    // Release and run all three instances
    @(negedge clk);
    rst_n = 1'b1;
    if0.timer_enable = 1'b1;
    if1.timer_enable = 1'b1;
    if2.timer_enable = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      // u0: one IDLE->RUN cycle, then one step per cycle down to 0.
      c0 = (k == 1) ? 15 : ((16 - k > 0) ? 16 - k : 0);
      chk("a.u0.number",   int'(if0.timer_number), c0);
      chk("a.u0.expire",   int'(if0.timer_expire), int'(k == 16));
      chk("a.u0.overflow", int'(if0.timer_overflow), int'(k >= 16));
      chk("a.u0.warn",     int'(if0.timer_warn), int'(WARN_EN && k >= 13 && k <= 15));
      // u1: ticks on edges 5, 9, 13, ...; sequence 3,2,1,0,3.
      t1 = (k - 1) / 4;
      c1 = 3 - (t1 % 4);
      chk("a.u1.number",   int'(if1.timer_number), c1);
      chk("a.u1.expire",   int'(if1.timer_expire), int'(k > 1 && (k - 1) % 4 == 0 && t1 % 4 == 3));
      chk("a.u1.overflow", int'(if1.timer_overflow), int'(t1 % 4 == 3));
      chk("a.u1.warn",     int'(if1.timer_warn), int'(WARN_EN && c1 != 0));
      // u2: ticks on edges 4, 7, 10; paused for edges 12..18 at count 9.
      if (k <= 11) c2 = 12 - (k - 1) / 3;
      else if (k <= 19) c2 = 9;
      else c2 = 12 - (4 + (k - 20) / 3);
      chk("a.u2.number", int'(if2.timer_number), c2);
      if (k == 11) if2.timer_enable = 1'b0;
      if (k == 18) if2.timer_enable = 1'b1;
    end
    chk("a.u0.state", int'(if0.timer_state), 2);

    // Load racing the 1->0 tick, then a zero load in one-shot
    drive0(1'b1, 1'b1, 2, 1'b0);
    step();
    drive0(1'b1, 1'b0, 0, 1'b0);
    chk("c.load2.number", int'(if0.timer_number), 2);
    chk("c.load2.state",  int'(if0.timer_state), 1);
    step();
    chk("c.tick.number", int'(if0.timer_number), 1);
    drive0(1'b1, 1'b1, 5, 1'b0);
    step();
    drive0(1'b1, 1'b0, 0, 1'b0);
    chk("c.race.number",   int'(if0.timer_number), 5);
    chk("c.race.overflow", int'(if0.timer_overflow), 0);
    chk("c.race.expire",   int'(if0.timer_expire), 0);
    step();
    chk("c.after.number", int'(if0.timer_number), 4);
    drive0(1'b1, 1'b1, 0, 1'b0);
    step();
    drive0(1'b1, 1'b0, 0, 1'b0);
    chk("c.zero.number",   int'(if0.timer_number), 0);
    chk("c.zero.overflow", int'(if0.timer_overflow), 1);
    chk("c.zero.expire",   int'(if0.timer_expire), 0);
    chk("c.zero.state",    int'(if0.timer_state), 2);
    step();
    chk("c.done.expire", int'(if0.timer_expire), 0);
    chk("c.done.state",  int'(if0.timer_state), 2);

    // Zero load in auto-reload, then a mode switch while sitting at 0
    drive0(1'b1, 1'b1, 0, 1'b1);
    step();
    drive0(1'b1, 1'b0, 0, 1'b1);
    chk("r.zero.number",   int'(if0.timer_number), 0);
    chk("r.zero.overflow", int'(if0.timer_overflow), 1);
    chk("r.zero.state",    int'(if0.timer_state), 1);
    step();
    chk("r.reload.number",   int'(if0.timer_number), 15);
    chk("r.reload.overflow", int'(if0.timer_overflow), 0);
    chk("r.reload.expire",   int'(if0.timer_expire), 0);
    repeat (14) step();
    chk("r.one.number", int'(if0.timer_number), 1);
    step();
    chk("r.exp.number", int'(if0.timer_number), 0);
    chk("r.exp.expire", int'(if0.timer_expire), 1);
    if0.timer_mode = 1'b0;
    step();
    chk("r.switch.state",    int'(if0.timer_state), 2);
    chk("r.switch.expire",   int'(if0.timer_expire), 0);
    chk("r.switch.overflow", int'(if0.timer_overflow), 1);

    // Asynchronous reset mid-count
    drive0(1'b1, 1'b1, 10, 1'b0);
    step();
    drive0(1'b1, 1'b0, 0, 1'b0);
    repeat (4) step();
    chk("d.pre.number", int'(if0.timer_number), 6);
    #1 rst_n = 1'b0;
    #1;
    chk("d.rst.number",   int'(if0.timer_number), 15);
    chk("d.rst.overflow", int'(if0.timer_overflow), 0);
    chk("d.rst.expire",   int'(if0.timer_expire), 0);
    chk("d.rst.warn",     int'(if0.timer_warn), 0);
    chk("d.rst.state",    int'(if0.timer_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    if0.timer_enable = 1'b0;
    repeat (3) begin
      step();
      chk("d.idle.number", int'(if0.timer_number), 15);
      chk("d.idle.state",  int'(if0.timer_state), 0);
    end
    if0.timer_enable = 1'b1;
    step();
    chk("d.run.state",  int'(if0.timer_state), 1);
    chk("d.run.number", int'(if0.timer_number), 15);
    step();
    chk("d.tick.number", int'(if0.timer_number), 14);

    repeat (3) @(negedge clk);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits, range 2..16.
REQ-002 Parameter INIT, default 15, reload value, range 1..2^WIDTH-1.
REQ-003 Parameter PRESCALE, default 1, timer_clk cycles per count step, range 1..65535.
REQ-004 Parameter WARN, default 3, warning threshold, range 0..INIT.
REQ-005 timer_clk  input  1  sole clock; all logic on rising edge.
REQ-006 timer_reset  input  1  asynchronous, active-low reset.
REQ-007 timer_enable  input  1  count enable; low pauses counting.
REQ-008 timer_load  input  1  synchronous load strobe.
REQ-009 timer_load_value  input  WIDTH  value taken on load.
REQ-010 timer_mode  input  1  0 one-shot, 1 auto-reload.
REQ-011 timer_number  output  WIDTH  current count, registered.
REQ-012 timer_overflow  output  1  level, high while count is 0 after expiry.
REQ-013 timer_expire  output  1  one-cycle pulse on each expiry.
REQ-014 timer_warn  output  1  high while RUN and 0 < count <= WARN.

Function
REQ-015 States: IDLE, RUN, DONE; IDLE -> RUN when timer_enable=1; DONE is left only by load or reset.
REQ-016 Tick: prescaler counts 0..PRESCALE-1 in RUN with timer_enable=1; tick fires on the cycle prescaler==PRESCALE-1, then prescaler returns to 0; PRESCALE=1 ticks every enabled cycle.
REQ-017 Pause: timer_enable=0 in RUN holds count, prescaler and state; resumes with no lost or extra tick.
REQ-018 Tick with count>1: count decrements by 1; overflow=0.
REQ-019 Tick with count==1: count->0, overflow=1, timer_expire=1 for exactly that one cycle; one-shot -> DONE; auto-reload stays RUN.
REQ-020 Auto-reload, tick with count==0: count->INIT, overflow->0, no pulse; period = INIT+1 ticks.
REQ-021 DONE: count held 0, overflow held 1, timer_enable ignored, no further pulses.
REQ-022 timer_mode is sampled at every tick, not latched; switching to one-shot while count==0 in RUN moves to DONE at the next tick.
REQ-023 Load has priority over tick in the same cycle: count<=timer_load_value, prescaler<=0, overflow<=0, pulse suppressed; next state RUN if timer_enable=1, else IDLE.
REQ-024 Load with value 0: count 0, overflow 1, no pulse; one-shot -> DONE; auto-reload -> RUN, next tick reloads INIT.
REQ-025 No wrap below 0: decrement is never applied at count 0.
REQ-026 timer_number, timer_overflow, timer_expire, timer_warn are all registered outputs.

Reset
REQ-027 timer_reset low forces immediately: count=INIT, overflow=0, expire=0, warn=0, prescaler=0, state IDLE.
REQ-028 Reset asserted mid-count or mid-pulse aborts all activity; first tick after release requires PRESCALE full enabled cycles in RUN.

Configuration
REQ-029 Macro COUNTDOWN_TIMER_WARN_EN: when defined, timer_warn behaves per REQ-014.
REQ-030 Without COUNTDOWN_TIMER_WARN_EN, the port remains, timer_warn is constant 0, and no comparator logic is built.

Verification
REQ-031 Defaults, enable held 1, one-shot: count 15,14,...,1,0 one per cycle; expire pulses once on the 1->0 cycle; overflow stays 1; count stays 0.
REQ-032 PRESCALE=4, INIT=3, auto-reload: count changes every 4 cycles 3,2,1,0,3; expire pulses every 16 cycles; overflow high only during 0.
REQ-033 Enable dropped for 7 cycles at count 9 mid-prescale: count and prescaler frozen; sequence resumes unchanged.
REQ-034 Load of 5 asserted on the same cycle as the 1->0 tick: count=5, overflow=0, no expire pulse; load of 0 in one-shot -> DONE, overflow=1, no pulse.
REQ-035 Reset pulsed low at count 6 in RUN: outputs return to 15/0/0/0 asynchronously; IDLE until enable.
REQ-036 With COUNTDOWN_TIMER_WARN_EN, WARN=3: warn high for counts 3,2,1, low at 0 and above 3; without the macro, warn is 0 throughout.
